dmem_arbiter: RTL

- Shares the single-port 256x16 data memory between the processor control unit (CPU side) and an external host port used for program/data loading and debug readback.
- Sits between the control unit's memory address and write-enable outputs, the datapath's write data and read data, and the data memory.
- CPU has priority. Host is guaranteed service after a bounded wait, enforced by stalling the CPU.

---
 rtl/dmem_arbiter.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// ----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one single-port data memory (synchronous read, 1-cycle latency)
// between the processor control unit (CPU side) and an external host port
// used for program/data loading and debug readback.
//
// The CPU owns the memory by default through a zero-latency combinational mux.
// A pending host request is granted as soon as the CPU leaves a cycle free.
// If the CPU keeps the memory busy, the host is granted once it has been
// refused STARVE_MAX times. The CPU is then stalled for one cycle.
//
// Every host transaction takes two cycles:
//   S_HOST : host drives the memory
//   S_ACK  : Host_Ack pulses, and the CPU owns the memory again
//
// Host_Req is ignored during S_ACK, which gives the host one cycle to release
// it.
//
// Parameters
//   ADDR_W      memory address width
//   DATA_W      memory word width
//   STARVE_MAX  host refusals tolerated before the CPU is stalled (1..15)
//
// Ports
//   Clock, Reset                      rising-edge clock, synchronous
//                                     active-high reset
//   Cpu_Req/Wr/Addr/WData, Cpu_Stall  CPU access; a stalled CPU holds its
//                                     request
//   Host_Req/Wr/Addr/WData            level request, held until Host_Ack
//   Host_Ack, Host_RData              completion pulse; read data, held until
//                                     the next host read completes
//   Mem_Addr/Wr/WData, Mem_RData      memory side
//   Stall_Count                       saturating count of CPU stall cycles
//
// Optional feature: define DMEM_ARB_STALL_CNT_EN to build the Stall_Count
// counter. Without it, Stall_Count is tied to zero.
// ----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 16,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Cpu_Req,
    input  logic              Cpu_Wr,
    input  logic [ADDR_W-1:0] Cpu_Addr,
    input  logic [DATA_W-1:0] Cpu_WData,
    output logic              Cpu_Stall,
    input  logic              Host_Req,
    input  logic              Host_Wr,
    input  logic [ADDR_W-1:0] Host_Addr,
    input  logic [DATA_W-1:0] Host_WData,
    output logic              Host_Ack,
    output logic [DATA_W-1:0] Host_RData,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_Wr,
    output logic [DATA_W-1:0] Mem_WData,
    input  logic [DATA_W-1:0] Mem_RData,
    output logic [7:0]        Stall_Count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOST = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    state_t            state_next;
    logic [3:0]        starve_cnt;
    logic              host_go;
    logic              host_rd;
    logic [DATA_W-1:0] rdata_q;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;

    // Grant the host when the CPU is idle, or when the host has waited long
    // enough.
    assign host_go = (state == S_IDLE) && Host_Req &&
                     (!Cpu_Req || (starve_cnt == STARVE_LIM));

    // ---------------- state register ----------------
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (host_go) state_next = S_HOST;
            S_HOST:  state_next = S_ACK;
            S_ACK:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // With no requester, the memory bus keeps the last address and data it
    // carried. Reset masks every side effect: no write, no stall, no ack.
    always_comb begin
        Mem_Addr  = addr_hold;
        Mem_WData = wdata_hold;
        Mem_Wr    = 1'b0;
        Cpu_Stall = 1'b0;
        Host_Ack  = 1'b0;
        if (state == S_HOST) begin
            Mem_Addr  = Host_Addr;
            Mem_WData = Host_WData;
            Mem_Wr    = Host_Wr;
            Cpu_Stall = Cpu_Req;
        end else begin
            if (Cpu_Req) begin
                Mem_Addr  = Cpu_Addr;
                Mem_WData = Cpu_WData;
                Mem_Wr    = Cpu_Wr;
            end
            Host_Ack = (state == S_ACK);
        end
        if (Reset) begin
            Mem_Wr    = 1'b0;
            Cpu_Stall = 1'b0;
            Host_Ack  = 1'b0;
        end
    end

    // Starvation counter. It counts refusals while the host is pending and
    // restarts from zero once the host is granted.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Host_Req && !host_go && (starve_cnt != STARVE_LIM)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end
                S_HOST:  starve_cnt <= 4'd0;
                default: ;
            endcase
        end
    end

    // Bus hold registers that supply the idle value of Mem_Addr and Mem_WData.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            addr_hold  <= Mem_Addr;
            wdata_hold <= Mem_WData;
        end
    end

    // Host read-back path.
    // The read issued in S_HOST returns on Mem_RData during S_ACK. It is
    // passed straight through while Host_Ack is high, and captured at the
    // edge that closes S_ACK. A host write leaves the captured value
    // untouched.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            host_rd <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == S_HOST) begin
                host_rd <= !Host_Wr;
            end
            if ((state == S_ACK) && host_rd) begin
                rdata_q <= Mem_RData;
            end
        end
    end

    assign Host_RData = (Host_Ack && host_rd) ? Mem_RData : rdata_q;

`ifdef DMEM_ARB_STALL_CNT_EN
    logic [7:0] stall_cnt;

    // Saturating count of CPU stall cycles.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            stall_cnt <= 8'd0;
        end else if (Cpu_Stall && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

    assign Stall_Count = stall_cnt;
`else
    assign Stall_Count = 8'd0;
`endif

endmodule
